// File: rtl/seg_pkg.sv
// Shared types and constants for the score-to-7-segment display path.
// Contents: score/digit widths, saturation limit, BCD digit type, controller
// state enum and the double-dabble nibble adjust helper.
package seg_pkg;

   localparam int unsigned SCORE_W    = 14;
   localparam logic [SCORE_W-1:0] SCORE_MAX = 14'd9999;
   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned BCD_W      = 4 * NUM_DIGITS;
   localparam int unsigned CNT_W      = 4;

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT
   } seg_score_state_e;

   // Add 3 to a nibble of 5 or more; the result never exceeds 12, so no carry out.
   function automatic bcd_t dabble_adj(input bcd_t d);
      return (d >= 4'd5) ? 4'(d + 4'd3) : d;
   endfunction

endpackage

// File: rtl/seg_blink_timer.sv
// Blink phase generator for the score display.
// Ports:
//   clk_i          clock
//   rst_i          asynchronous active-high reset
//   blink_i        1 = run the blink counter, 0 = hold counter and phase cleared
//   blink_phase_o  1 = display should be blanked
// The phase toggles every HALF_PERIOD cycles while blink_i is high, so the
// first blank phase starts HALF_PERIOD cycles after blink_i rises.
module seg_blink_timer #(
   parameter int unsigned HALF_PERIOD = 500
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic blink_i,
   output logic blink_phase_o
);

   localparam int unsigned CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

   logic [CNT_W-1:0] cnt_q;

   // Half-period counter and phase flop; dropping blink_i clears both.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q         <= '0;
         blink_phase_o <= 1'b0;
      end else if (!blink_i) begin
         cnt_q         <= '0;
         blink_phase_o <= 1'b0;
      end else if (cnt_q == CNT_W'(HALF_PERIOD - 1)) begin
         cnt_q         <= '0;
         blink_phase_o <= ~blink_phase_o;
      end else begin
         cnt_q <= CNT_W'(cnt_q + 1'b1);
      end
   end

endmodule

// File: rtl/seg_score_ctrl.sv
// Score-to-display controller for the Dino_run 7-segment path.
// Accepts a binary score over valid/ready, saturates it to 9999, converts it
// to four BCD digits with an iterative double-dabble engine (14 shifts) and
// registers digits plus leading-zero-blanking enables for the 4-digit driver.
// Optional macro SEG_SCORE_BLINK_EN adds a whole-display blink mask.
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   score_i, score_valid_i        score input and its valid
//   score_ready_o, busy_o         idle/accepting, conversion in progress
//   blank_lz_i                    1 = suppress leading zeros
//   blink_i                       1 = flash display (blink build only)
//   digit0_o..digit3_o            BCD digits, digit0 least significant
//   digit0_en_o..digit3_en_o      per-digit display enables
module seg_score_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned BLINK_HALF_PERIOD = 500
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [SCORE_W-1:0] score_i,
   input  logic               score_valid_i,
   output logic               score_ready_o,
   output logic               busy_o,
   input  logic               blank_lz_i,
   input  logic               blink_i,
   output logic [3:0]         digit0_o,
   output logic [3:0]         digit1_o,
   output logic [3:0]         digit2_o,
   output logic [3:0]         digit3_o,
   output logic               digit0_en_o,
   output logic               digit1_en_o,
   output logic               digit2_en_o,
   output logic               digit3_en_o
);

   seg_score_state_e state_q, state_d;
   logic [SCORE_W-1:0]    shift_q, shift_d;
   logic [BCD_W-1:0]      bcd_q, bcd_d, bcd_adj;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [BCD_W-1:0]      digits_q, digits_d;
   logic [NUM_DIGITS-1:0] en_q, en_d, en_out;
   logic [BCD_W+SCORE_W-1:0] shifted;
   logic                  ready_q, busy_q;

   // Next-state and datapath for the load / shift / commit sequence.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bcd_d    = bcd_q;
      cnt_d    = cnt_q;
      digits_d = digits_q;
      en_d     = en_q;
      bcd_adj  = bcd_q;
      shifted  = {bcd_q, shift_q};

      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         bcd_adj[i*4 +: 4] = dabble_adj(bcd_q[i*4 +: 4]);
      end

      unique case (state_q)
         IDLE: begin
            if (score_valid_i) begin
               shift_d = (score_i > SCORE_MAX) ? SCORE_MAX : score_i;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            shifted = {bcd_adj, shift_q} << 1;
            bcd_d   = shifted[BCD_W+SCORE_W-1:SCORE_W];
            shift_d = shifted[SCORE_W-1:0];
            cnt_d   = CNT_W'(cnt_q + 1'b1);
            // This edge performs the last of the SCORE_W shifts.
            if (cnt_q == CNT_W'(SCORE_W - 1)) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            digits_d = bcd_q;
            en_d[0]  = 1'b1;
            en_d[1]  = !blank_lz_i || ((bcd_q[15:12] | bcd_q[11:8] | bcd_q[7:4]) != 4'd0);
            en_d[2]  = !blank_lz_i || ((bcd_q[15:12] | bcd_q[11:8]) != 4'd0);
            en_d[3]  = !blank_lz_i || (bcd_q[15:12] != 4'd0);
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, conversion datapath and registered outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         digits_q <= '0;
         en_q     <= NUM_DIGITS'(1);
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         bcd_q    <= bcd_d;
         cnt_q    <= cnt_d;
         digits_q <= digits_d;
         en_q     <= en_d;
         ready_q  <= (state_d == IDLE);
         busy_q   <= (state_d != IDLE);
      end
   end

`ifdef SEG_SCORE_BLINK_EN
   logic blink_phase;

   seg_blink_timer #(
      .HALF_PERIOD (BLINK_HALF_PERIOD)
   ) u_blink (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .blink_i       (blink_i),
      .blink_phase_o (blink_phase)
   );

   // Blank phase masks all enables after the enable registers.
   assign en_out = en_q & {NUM_DIGITS{~blink_phase}};
`else
   logic unused_blink;

   assign unused_blink = blink_i ^ (BLINK_HALF_PERIOD == 0);
   assign en_out       = en_q;
`endif

   assign score_ready_o = ready_q;
   assign busy_o        = busy_q;
   assign digit0_o      = digits_q[3:0];
   assign digit1_o      = digits_q[7:4];
   assign digit2_o      = digits_q[11:8];
   assign digit3_o      = digits_q[15:12];
   assign digit0_en_o   = en_out[0];
   assign digit1_en_o   = en_out[1];
   assign digit2_en_o   = en_out[2];
   assign digit3_en_o   = en_out[3];

endmodule

// File: tb/tb_seg_score_ctrl.sv
// Directed self-checking bench for seg_score_ctrl.
module tb_seg_score_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [13:0] score_i;
   logic        score_valid_i;
   logic        score_ready_o;
   logic        busy_o;
   logic        blank_lz_i;
   logic        blink_i;
   logic [3:0]  digit0_o, digit1_o, digit2_o, digit3_o;
   logic        digit0_en_o, digit1_en_o, digit2_en_o, digit3_en_o;

   int checks = 0;
   int errors = 0;

   seg_score_ctrl #(
      .BLINK_HALF_PERIOD (4)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .score_i       (score_i),
      .score_valid_i (score_valid_i),
      .score_ready_o (score_ready_o),
      .busy_o        (busy_o),
      .blank_lz_i    (blank_lz_i),
      .blink_i       (blink_i),
      .digit0_o      (digit0_o),
      .digit1_o      (digit1_o),
      .digit2_o      (digit2_o),
      .digit3_o      (digit3_o),
      .digit0_en_o   (digit0_en_o),
      .digit1_en_o   (digit1_en_o),
      .digit2_en_o   (digit2_en_o),
      .digit3_en_o   (digit3_en_o)
   );

   always #5 clk_i = ~clk_i;

   wire [15:0] digits = {digit3_o, digit2_o, digit1_o, digit0_o};
   wire [3:0]  ens    = {digit3_en_o, digit2_en_o, digit1_en_o, digit0_en_o};

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for ready, then perform one handshake; returns just after T0.
   task automatic start(input logic [13:0] s, input logic blk);
      int n = 0;
      while (score_ready_o !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("ready_before_start", 32'(score_ready_o), 32'd1);
      score_i       = s;
      blank_lz_i    = blk;
      score_valid_i = 1'b1;
      tick();
      score_valid_i = 1'b0;
      chk("busy_after_handshake", 32'(busy_o), 32'd1);
   endtask

   // Full conversion: check outputs hold at T14, then new values at T15.
   task automatic convert(input string tag, input logic [13:0] s, input logic blk,
                          input logic [15:0] prev_d, input logic [3:0] prev_e,
                          input logic [15:0] exp_d, input logic [3:0] exp_e);
      start(s, blk);
      repeat (14) tick();
      chk({tag, "_ready_T14"}, 32'(score_ready_o), 32'd0);
      chk({tag, "_hold_digits_T14"}, 32'(digits), 32'(prev_d));
      chk({tag, "_hold_en_T14"}, 32'(ens), 32'(prev_e));
      tick();
      chk({tag, "_ready_T15"}, 32'(score_ready_o), 32'd1);
      chk({tag, "_digits"}, 32'(digits), 32'(exp_d));
      chk({tag, "_en"}, 32'(ens), 32'(exp_e));
   endtask

   initial begin
      rst_i         = 1'b1;
      score_i       = '0;
      score_valid_i = 1'b0;
      blank_lz_i    = 1'b1;
      blink_i       = 1'b0;
      tick();
      tick();
      chk("rst_ready", 32'(score_ready_o), 32'd1);
      rst_i = 1'b0;
      tick();
      chk("reset_ready", 32'(score_ready_o), 32'd1);
      chk("reset_busy", 32'(busy_o), 32'd0);
      chk("reset_digits", 32'(digits), 32'h0000);
      chk("reset_en", 32'(ens), 32'b0001);

      convert("s1234", 14'd1234, 1'b1, 16'h0000, 4'b0001, 16'h1234, 4'b1111);
      convert("s7_lz", 14'd7, 1'b1, 16'h1234, 4'b1111, 16'h0007, 4'b0001);
      convert("s7_nolz", 14'd7, 1'b0, 16'h0007, 4'b0001, 16'h0007, 4'b1111);
      convert("s12000", 14'd12000, 1'b1, 16'h0007, 4'b1111, 16'h9999, 4'b1111);
      convert("s0_lz", 14'd0, 1'b1, 16'h9999, 4'b1111, 16'h0000, 4'b0001);

      // Valid pulse with 5678 during conversion of 42 is ignored.
      start(14'd42, 1'b1);
      repeat (2) tick();
      score_i       = 14'd5678;
      score_valid_i = 1'b1;
      tick();
      score_valid_i = 1'b0;
      chk("ignore_ready_low", 32'(score_ready_o), 32'd0);
      repeat (11) tick();
      chk("ignore_ready_T14", 32'(score_ready_o), 32'd0);
      tick();
      chk("ignore_digits", 32'(digits), 32'h0042);
      chk("ignore_en", 32'(ens), 32'b0011);

`ifndef SEG_SCORE_BLINK_EN
      // Blink request has no effect without the blink build.
      blink_i = 1'b1;
      repeat (9) tick();
      chk("noblink_en", 32'(ens), 32'b0011);
      blink_i = 1'b0;
`endif

      // Reset at T7 aborts the conversion.
      start(14'd1234, 1'b0);
      repeat (7) tick();
      rst_i = 1'b1;
      #1;
      chk("midrst_digits", 32'(digits), 32'h0000);
      chk("midrst_en", 32'(ens), 32'b0001);
      chk("midrst_ready", 32'(score_ready_o), 32'd1);
      tick();
      rst_i = 1'b0;
      repeat (20) tick();
      chk("midrst_no_commit_digits", 32'(digits), 32'h0000);
      chk("midrst_no_commit_en", 32'(ens), 32'b0001);
      chk("midrst_busy", 32'(busy_o), 32'd0);

      // Back-to-back with valid held: 100 then 9999 accepted at T16.
      score_i       = 14'd100;
      blank_lz_i    = 1'b1;
      score_valid_i = 1'b1;
      tick();
      score_i = 14'd9999;
      chk("b2b_busy_T0", 32'(busy_o), 32'd1);
      repeat (15) tick();
      chk("b2b_ready_T15", 32'(score_ready_o), 32'd1);
      chk("b2b_first_digits", 32'(digits), 32'h0100);
      chk("b2b_first_en", 32'(ens), 32'b0111);
      tick();
      score_valid_i = 1'b0;
      chk("b2b_accept_T16", 32'(score_ready_o), 32'd0);
      chk("b2b_hold_T16", 32'(digits), 32'h0100);
      repeat (15) tick();
      chk("b2b_second_digits", 32'(digits), 32'h9999);
      chk("b2b_second_en", 32'(ens), 32'b1111);

`ifdef SEG_SCORE_BLINK_EN
      // Blink with half period 4: show 3 more cycles, blank 4, show 4.
      blink_i = 1'b1;
      repeat (3) tick();
      chk("blink_show_E3", 32'(ens), 32'b1111);
      tick();
      chk("blink_blank_E4", 32'(ens), 32'b0000);
      repeat (3) tick();
      chk("blink_blank_E7", 32'(ens), 32'b0000);
      tick();
      chk("blink_show_E8", 32'(ens), 32'b1111);
      repeat (3) tick();
      chk("blink_show_E11", 32'(ens), 32'b1111);
      tick();
      chk("blink_blank_E12", 32'(ens), 32'b0000);
      blink_i = 1'b0;
      tick();
      chk("blink_restore", 32'(ens), 32'b1111);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
